// File: rtl/sram_log_reader.sv
// sram_log_reader: walks a block of logged 16-bit samples in the external
// async SRAM and streams them out one word at a time over valid/ready.
// Read-only: the data bus is never driven from this side.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | SRAM released, waiting for start
// S_SETUP   | address presented, CE/OE asserted (one cycle)
// S_WAIT    | access time elapsing; datos sampled when the counter hits 0
// S_PRESENT | SRAM released, rd_data offered until the consumer takes it
module sram_log_reader #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [17:0] base_addr,
    input  logic [17:0] word_count,
    output logic [4:0]  sram_control,
    output logic [17:0] direcciones,
    inout  wire  [15:0] datos,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_WAIT    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    // {ce,oe,we,ub,lb}, active-low; we stays high in both encodings
    localparam logic [4:0] CTRL_OFF  = 5'b11111;
    localparam logic [4:0] CTRL_READ = 5'b00111;

    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYCLES - 1);

    state_t         state_q, state_nx;
    logic [17:0]    cnt_q, cnt_nx;
    logic [WW-1:0]  wait_q, wait_nx;
    logic [17:0]    addr_nx;
    logic [4:0]     ctrl_nx;
    logic [15:0]    data_nx;
    logic           valid_nx;
    logic           done_nx;

    // The reader only ever samples the bus.
    assign datos = 16'hzzzz;

    // State and registered outputs; reset drops the SRAM at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            direcciones  <= '0;
            sram_control <= CTRL_OFF;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_nx;
            cnt_q        <= cnt_nx;
            wait_q       <= wait_nx;
            direcciones  <= addr_nx;
            sram_control <= ctrl_nx;
            rd_data      <= data_nx;
            rd_valid     <= valid_nx;
            busy         <= (state_nx != S_IDLE);
            done         <= done_nx;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        wait_nx  = wait_q;
        addr_nx  = direcciones;
        ctrl_nx  = sram_control;
        data_nx  = rd_data;
        valid_nx = rd_valid;
        done_nx  = 1'b0;

        if (state_q != S_IDLE && abort) begin
            // abort wins over a same-cycle handshake and never pulses done
            state_nx = S_IDLE;
            ctrl_nx  = CTRL_OFF;
            valid_nx = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ctrl_nx = CTRL_OFF;
                    if (start) begin
                        if (word_count != 18'd0) begin
                            state_nx = S_SETUP;
                            addr_nx  = base_addr;
                            cnt_nx   = word_count;
                            ctrl_nx  = CTRL_READ;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    state_nx = S_WAIT;
                    wait_nx  = WAIT_LOAD;
                    ctrl_nx  = CTRL_READ;
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_nx = S_PRESENT;
                        data_nx  = datos;
                        valid_nx = 1'b1;
                        ctrl_nx  = CTRL_OFF;
                    end else begin
                        wait_nx = wait_q - WW'(1);
                    end
                end
                S_PRESENT: begin
                    ctrl_nx = CTRL_OFF;
                    if (rd_ready) begin
                        valid_nx = 1'b0;
                        if (cnt_q > 18'd1) begin
                            // 18-bit address wraps naturally past 3FFFF
                            state_nx = S_SETUP;
                            addr_nx  = direcciones + 18'd1;
                            cnt_nx   = cnt_q - 18'd1;
                            ctrl_nx  = CTRL_READ;
                        end else begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    ctrl_nx  = CTRL_OFF;
                    valid_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_log_reader.sv
// Directed bench for sram_log_reader with a small async SRAM model.
module tb_sram_log_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        rd_ready;
    logic [17:0] base_addr;
    logic [17:0] word_count;
    wire  [4:0]  sram_control;
    wire  [17:0] direcciones;
    wire  [15:0] datos;
    wire  [15:0] rd_data;
    wire         rd_valid;
    wire         busy;
    wire         done;

    int checks = 0;
    int errors = 0;
    int we_low_seen = 0;

    sram_log_reader #(.WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .sram_control (sram_control),
        .direcciones  (direcciones),
        .datos        (datos),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .busy         (busy),
        .done         (done)
    );

    // SRAM contents: two fixed samples, everything else addr[15:0]+1111
    function automatic logic [15:0] mem_word(input logic [17:0] a);
        if (a == 18'h00100) return 16'hA5A5;
        if (a == 18'h00101) return 16'h1234;
        return a[15:0] + 16'h1111;
    endfunction

    assign datos = (!sram_control[4] && !sram_control[3] && sram_control[2])
                   ? mem_word(direcciones) : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (sram_control[2] !== 1'b1) we_low_seen++;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
        base_addr = '0; word_count = '0;
        #2 reset = 1'b0;
        #2;
        checks++;
        if (sram_control !== 5'b11111 || direcciones !== 18'h0 || rd_data !== 16'h0 ||
            rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values ctrl=%b addr=%h data=%h valid=%b busy=%b done=%b want 11111 00000 0000 0 0 0",
                     sram_control, direcciones, rd_data, rd_valid, busy, done);
        end
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || sram_control !== 5'b11111 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b ctrl=%b done=%b want 0 11111 0", busy, sram_control, done);
        end
    endtask

    task automatic test_two_words();
        rd_ready = 1'b1; base_addr = 18'h00100; word_count = 18'd2; start = 1'b1;
        step();                         // E0
        start = 1'b0;
        checks++;
        if (sram_control !== 5'b00111 || direcciones !== 18'h00100 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_setup ctrl=%b addr=%h busy=%b valid=%b want 00111 00100 1 0",
                     sram_control, direcciones, busy, rd_valid);
        end
        step(); step();                 // E0+2
        checks++;
        if (rd_valid !== 1'b0 || sram_control !== 5'b00111) begin
            errors++;
            $display("FAIL two_early_valid valid=%b ctrl=%b want 0 00111", rd_valid, sram_control);
        end
        step();                         // E0+3
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5 || sram_control !== 5'b11111) begin
            errors++;
            $display("FAIL two_word0 valid=%b data=%h ctrl=%b want 1 a5a5 11111", rd_valid, rd_data, sram_control);
        end
        step();                         // E0+4
        checks++;
        if (rd_valid !== 1'b0 || direcciones !== 18'h00101 || sram_control !== 5'b00111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL two_next_setup valid=%b addr=%h ctrl=%b busy=%b want 0 00101 00111 1",
                     rd_valid, direcciones, sram_control, busy);
        end
        step(); step(); step();         // E0+7
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1234 || done !== 1'b0) begin
            errors++;
            $display("FAIL two_word1 valid=%b data=%h done=%b want 1 1234 0", rd_valid, rd_data, done);
        end
        step();                         // E0+8
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || sram_control !== 5'b11111) begin
            errors++;
            $display("FAIL two_done done=%b busy=%b valid=%b ctrl=%b want 1 0 0 11111",
                     done, busy, rd_valid, sram_control);
        end
        step();                         // E0+9
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL two_done_width done=%b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0; base_addr = 18'h00200; word_count = 18'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h1311 || sram_control !== 5'b11111 ||
                direcciones !== 18'h00200 || done !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d valid=%b data=%h ctrl=%b addr=%h done=%b want 1 1311 11111 00200 0",
                         i, rd_valid, rd_data, sram_control, direcciones, done);
            end
            step();
        end
        rd_ready = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_resume done=%b valid=%b busy=%b want 1 0 0", done, rd_valid, busy);
        end
    endtask

    task automatic test_addr_wrap();
        rd_ready = 1'b1; base_addr = 18'h3FFFF; word_count = 18'd2; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (direcciones !== 18'h3FFFF) begin
            errors++;
            $display("FAIL wrap_addr0 addr=%h want 3ffff", direcciones);
        end
        step(); step(); step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1110) begin
            errors++;
            $display("FAIL wrap_data0 valid=%b data=%h want 1 1110", rd_valid, rd_data);
        end
        step();
        checks++;
        if (direcciones !== 18'h00000 || sram_control !== 5'b00111) begin
            errors++;
            $display("FAIL wrap_addr1 addr=%h ctrl=%b want 00000 00111", direcciones, sram_control);
        end
        step(); step(); step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1111) begin
            errors++;
            $display("FAIL wrap_data1 valid=%b data=%h want 1 1111", rd_valid, rd_data);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done done=%b busy=%b want 1 0", done, busy);
        end
        step();
    endtask

    task automatic test_zero_and_busy_start();
        rd_ready = 1'b0; base_addr = 18'h00055; word_count = 18'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sram_control !== 5'b11111) begin
            errors++;
            $display("FAIL zero_done done=%b busy=%b ctrl=%b want 1 0 11111", done, busy, sram_control);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sram_control !== 5'b11111) begin
            errors++;
            $display("FAIL zero_after done=%b busy=%b ctrl=%b want 0 0 11111", done, busy, sram_control);
        end
        base_addr = 18'h00010; word_count = 18'd1; start = 1'b1;
        step();                         // E0
        start = 1'b0;
        step();                         // E0+1, in WAIT
        base_addr = 18'h00020; word_count = 18'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();                         // E0+3
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1121 || direcciones !== 18'h00010) begin
            errors++;
            $display("FAIL busy_start valid=%b data=%h addr=%h want 1 1121 00010", rd_valid, rd_data, direcciones);
        end
        rd_ready = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_done done=%b busy=%b want 1 0", done, busy);
        end
        step();
    endtask

    task automatic test_abort_wait();
        int done_seen = 0;
        rd_ready = 1'b1; base_addr = 18'h00300; word_count = 18'd5; start = 1'b1;
        step();                         // E0
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) done_seen++;
        end                             // E0+8, word 3 SETUP
        checks++;
        if (direcciones !== 18'h00302 || sram_control !== 5'b00111) begin
            errors++;
            $display("FAIL abort_pre addr=%h ctrl=%b want 00302 00111", direcciones, sram_control);
        end
        step();                         // E0+9, WAIT
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || sram_control !== 5'b11111 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy=%b valid=%b ctrl=%b done=%b want 0 0 11111 0",
                     busy, rd_valid, sram_control, done);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done events=%0d want 0", done_seen);
        end
    endtask

    task automatic test_abort_vs_handshake();
        rd_ready = 1'b0; base_addr = 18'h00040; word_count = 18'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1151) begin
            errors++;
            $display("FAIL abort_hs_data valid=%b data=%h want 1 1151", rd_valid, rd_data);
        end
        rd_ready = 1'b1; abort = 1'b1;
        step();
        rd_ready = 1'b0; abort = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_hs done=%b busy=%b valid=%b want 0 0 0", done, busy, rd_valid);
        end
        step();
    endtask

    task automatic test_async_reset();
        rd_ready = 1'b1; base_addr = 18'h00100; word_count = 18'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();                         // in WAIT
        checks++;
        if (busy !== 1'b1 || sram_control !== 5'b00111) begin
            errors++;
            $display("FAIL areset_pre busy=%b ctrl=%b want 1 00111", busy, sram_control);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (sram_control !== 5'b11111 || direcciones !== 18'h0 || rd_data !== 16'h0 ||
            rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_now ctrl=%b addr=%h data=%h valid=%b busy=%b done=%b want 11111 00000 0000 0 0 0",
                     sram_control, direcciones, rd_data, rd_valid, busy, done);
        end
        step();
        reset = 1'b1;
        step(); step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sram_control !== 5'b11111) begin
            errors++;
            $display("FAIL areset_after busy=%b done=%b ctrl=%b want 0 0 11111", busy, done, sram_control);
        end
    endtask

    task automatic test_we_never_low();
        checks++;
        if (we_low_seen != 0) begin
            errors++;
            $display("FAIL we_low cycles=%0d want 0", we_low_seen);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_backpressure();
        test_addr_wrap();
        test_zero_and_busy_start();
        test_abort_wait();
        test_abort_vs_handshake();
        test_async_reset();
        test_we_never_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
